// File: rtl/instruction_fetch.sv
// Fetch PC and prefetch queue in front of a combinational instruction memory (option: IFETCH_MISALIGN_CHECK_EN).
// Latency: address presented in cycle N appears at the queue head in N+1; a redirect restarts output two cycles later.
// Backpressure: fetch stalls while the queue is full and not popping; out_ready_i low holds the head.
module instruction_fetch #(
  parameter int unsigned        RegBits = 32,
  parameter int unsigned        Depth   = 2,
  parameter logic [RegBits-1:0] ResetPc = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic [RegBits-1:0] imem_addr_o,
  input  logic [RegBits-1:0] imem_rd_i,
  input  logic               redirect_i,
  input  logic [RegBits-1:0] redirect_pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [RegBits-1:0] out_instr_o,
  output logic [RegBits-1:0] out_pc_o,
  output logic               misaligned_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [RegBits-1:0] pc;
    logic [RegBits-1:0] instr;
  } entry_t;

  entry_t             mem [Depth];
  logic [PtrW-1:0]    rd_ptr;
  logic [PtrW-1:0]    wr_ptr;
  logic [CntW-1:0]    count;
  logic [RegBits-1:0] fetch_pc;
  logic               pop;
  logic               room;
  logic               push;

  assign pop  = (count != '0) & out_ready_i;
  // A pop in the same cycle frees the slot the push needs.
  assign room = (count < CntW'(Depth)) | pop;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic halted;
  logic misalign;
  logic fetch_req;

  assign misalign  = fetch_pc[1:0] != 2'b00;
  assign fetch_req = ~redirect_i & ~halted & room;
  assign push      = fetch_req & ~misalign;

  // Sticky until steered to an aligned target; a misaligned redirect leaves it set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      halted <= 1'b0;
    end else if (redirect_i) begin
      if (redirect_pc_i[1:0] == 2'b00) halted <= 1'b0;
    end else if (fetch_req & misalign) begin
      halted <= 1'b1;
    end
  end

  assign misaligned_o = halted;
`else
  assign push         = ~redirect_i & room;
  assign misaligned_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc <= ResetPc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      mem      <= '{default: '0};
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_rd_i};
        wr_ptr      <= wr_ptr + PtrW'(1);
        fetch_pc    <= fetch_pc + RegBits'(4);
      end
      if (pop) rd_ptr <= rd_ptr + PtrW'(1);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  assign imem_addr_o = fetch_pc;
  assign out_valid_o = count != '0;
  assign out_pc_o    = mem[rd_ptr].pc;
  assign out_instr_o = mem[rd_ptr].instr;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and prefetch stage sitting directly upstream of the combinational instruction memory. It owns the fetch PC, drives the memory byte address and captures the returned 32-bit word together with its PC into a small FIFO. Decode drains the FIFO through a valid/ready handshake. A redirect from execute (branch/jump) flushes the queue and restarts fetch at a new PC.

## Interface
- RegBits, 32, width of PC, address and instruction word
- Depth, 2, prefetch FIFO entries; power of two, ≥ 2
- ResetPc, 32'h0000_0000, fetch PC after reset
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  reset; asynchronous, active-low
- imem_addr_o  output  RegBits  byte address to instruction memory; equals fetch PC
- imem_rd_i  input  RegBits  instruction word returned combinationally for imem_addr_o in the same cycle
- redirect_i  input  1  flush and restart fetch this cycle
- redirect_pc_i  input  RegBits  new fetch PC, sampled when redirect_i = 1
- out_valid_o  output  1  FIFO head holds a valid instruction
- out_ready_i  input  1  decode accepts the head this cycle
- out_instr_o  output  RegBits  instruction word at FIFO head
- out_pc_o  output  RegBits  PC of instruction at FIFO head
- misaligned_o  output  1  fetch halted on misaligned PC (only with IFETCH_MISALIGN_CHECK_EN; else tied 0)

## Operation
- State: fetch_pc register, FIFO storage of Depth × {pc, instr}, read/write pointers, count (clog2(Depth)+1 bits).
- pop = out_valid_o & out_ready_i. push = ~redirect_i & ~halted & (count < Depth | pop).
- On push: write {fetch_pc, imem_rd_i} at write pointer; fetch_pc ← fetch_pc + 4, modulo 2^RegBits (wraps 0xFFFF_FFFC → 0).
- On pop: read pointer advances; head outputs show next entry.
- Push and pop in same cycle when full: both occur, count unchanged.
- Redirect (priority over push): count ← 0, pointers ← 0, fetch_pc ← redirect_pc_i, no push. A pop asserted in the redirect cycle still counts as accepted by decode.
- out_valid_o = (count != 0). out_instr_o/out_pc_o come from storage at read pointer; storage resets to 0.
- Instruction word is taken from imem_rd_i unmodified (memory already assembles bytes a..a+3).

## Timing
- Reset values: fetch_pc = ResetPc, imem_addr_o = ResetPc, count 0, out_valid_o 0, out_instr_o 0, out_pc_o 0, misaligned_o 0.
- imem_addr_o is a direct register output; imem path is combinational so push happens the same cycle the address is presented.
- Fetch-to-valid latency: 1 cycle (address in cycle N → out_valid_o in N+1).
- Redirect in cycle N: out_valid_o = 0 in N+1, imem_addr_o = redirect_pc_i in N+1, first redirected instruction valid in N+2.
- Steady state with out_ready_i held 1: one instruction per cycle.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously); queue contents lost.

## Configuration
- IFETCH_MISALIGN_CHECK_EN defined: if fetch_pc[1:0] != 0 at a would-be push, no push occurs, a halted flag is set and misaligned_o = 1 from the next cycle; the flag holds until a redirect_i with redirect_pc_i[1:0] == 0 (cleared the cycle after) or reset. Queued entries still drain normally.
- Not defined: no check; misaligned PCs are fetched as-is, misaligned_o tied 0, no halted state.

## Test plan
- Reset release with out_ready_i = 1, ROM words W0..W3 at 0x0,0x4,0x8,0xC -> out_valid_o rises 1 cycle after reset; out_pc_o/out_instr_o = 0x0/W0, 0x4/W1, 0x8/W2 on consecutive cycles.
- out_ready_i = 0 for 5 cycles -> count saturates at Depth, imem_addr_o stops at 0x8, head stays 0x0; ready back to 1 -> sequence resumes with no skipped or duplicated PC.
- Full FIFO with out_ready_i = 1 -> simultaneous push/pop each cycle, one instruction per cycle, count stays Depth.
- redirect_i with redirect_pc_i = 0x40 while FIFO holds 0x8, 0xC -> out_valid_o 0 next cycle, next valid head is pc 0x40 two cycles after redirect; 0x8/0xC never appear.
- redirect_pc_i = 0xFFFF_FFFC -> subsequent out_pc_o values 0xFFFF_FFFC then 0x0000_0000.
- IFETCH_MISALIGN_CHECK_EN: redirect to 0x42 -> misaligned_o = 1, out_valid_o stays 0; redirect to 0x44 -> misaligned_o = 0 next cycle, pc 0x44 valid two cycles after redirect.
